// File: rtl/alu_serial.sv
// Multi-cycle ALU with a valid/ready handshake: shifts run one bit per cycle, everything else
// completes in one cycle. Define ALU_SERIAL_BARREL_EN for a single-cycle barrel shifter.
module alu_serial #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,        // active low, asynchronous
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [4:0]      i_req_function,
    input  logic [XLEN-1:0] i_req_a,
    input  logic [XLEN-1:0] i_req_b,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_result,
    output logic            o_resp_zero,
    output logic            o_resp_illegal
);
    localparam int unsigned SW = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SEQ  = 5'b10000;

`ifdef ALU_SERIAL_BARREL_EN
    typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_acc;
    logic            r_illegal;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic [SW-1:0]   w_shamt;
`ifndef ALU_SERIAL_BARREL_EN
    logic [4:0]      r_func;
    logic [SW-1:0]   r_count;
    logic            w_is_shift;
    logic [XLEN-1:0] w_acc_shift;
`endif

    assign w_shamt = i_req_b[SW-1:0];

    // Result for the request presented in IDLE; serial shifts just seed the accumulator.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
`ifndef ALU_SERIAL_BARREL_EN
        w_is_shift = 1'b0;
`endif
        case (i_req_function)
            ALU_ADD:  w_result = i_req_a + i_req_b;
            ALU_SUB:  w_result = i_req_a - i_req_b;
            ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, $signed(i_req_a) < $signed(i_req_b)};
            ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, i_req_a < i_req_b};
            ALU_SEQ:  w_result = {{(XLEN-1){1'b0}}, i_req_a == i_req_b};
            ALU_XOR:  w_result = i_req_a ^ i_req_b;
            ALU_OR:   w_result = i_req_a | i_req_b;
            ALU_AND:  w_result = i_req_a & i_req_b;
`ifdef ALU_SERIAL_BARREL_EN
            ALU_SLL:  w_result = i_req_a << w_shamt;
            ALU_SRL:  w_result = i_req_a >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(i_req_a) >>> w_shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                w_result   = i_req_a;
                w_is_shift = 1'b1;
            end
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

`ifndef ALU_SERIAL_BARREL_EN
    always_comb begin
        w_acc_shift = r_acc;
        case (r_func)
            ALU_SLL: w_acc_shift = {r_acc[XLEN-2:0], 1'b0};
            ALU_SRL: w_acc_shift = {1'b0, r_acc[XLEN-1:1]};
            ALU_SRA: w_acc_shift = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_shift = r_acc;
        endcase
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
`ifdef ALU_SERIAL_BARREL_EN
                    w_state_next = StDone;
`else
                    w_state_next = (w_is_shift && (w_shamt != '0)) ? StShift : StDone;
`endif
                end
            end
`ifndef ALU_SERIAL_BARREL_EN
            StShift: begin
                if (r_count == SW'(1)) begin
                    w_state_next = StDone;
                end
            end
`endif
            StDone: begin
                if (i_resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_acc     <= '0;
            r_illegal <= 1'b0;
`ifndef ALU_SERIAL_BARREL_EN
            r_func    <= '0;
            r_count   <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_acc     <= w_result;
                        r_illegal <= w_illegal;
`ifndef ALU_SERIAL_BARREL_EN
                        r_func    <= i_req_function;
                        r_count   <= w_shamt;
`endif
                    end
                end
`ifndef ALU_SERIAL_BARREL_EN
                StShift: begin
                    r_acc   <= w_acc_shift;
                    r_count <= r_count - SW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        o_req_ready    = (r_state == StIdle);
        o_resp_valid   = (r_state == StDone);
        o_resp_result  = r_acc;
        o_resp_zero    = (r_acc == '0);
        o_resp_illegal = r_illegal;
    end
endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial: latency, results, hold, abort-by-reset, illegal.
// Honours ALU_SERIAL_BARREL_EN for the expected shift latency.
module tb_alu_serial;
    localparam int unsigned XLEN = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SEQ  = 5'b10000;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_function;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_zero;
    logic            resp_illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_serial #(.XLEN(XLEN)) u_dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_function (req_function),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_result  (resp_result),
        .o_resp_zero    (resp_zero),
        .o_resp_illegal (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int shift_lat(input int k);
`ifdef ALU_SERIAL_BARREL_EN
        return 1;
`else
        return k + 1;
`endif
    endfunction

    // Issue one request, measure cycles to resp_valid, hold the response for 'hold' cycles.
    task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input logic exp_ill, input int hold);
        int   lat;
        logic ready_seen;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_function = f;
        req_a        = a;
        req_b        = b;
        resp_ready   = 1'b0;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_function = 5'b11111;
        req_a        = 32'hDEAD_BEEF;
        req_b        = 32'h0000_0003;
        lat          = 1;
        ready_seen   = 1'b0;
        while (!resp_valid && lat < 100) begin
            if (req_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_ready"}, 32'(ready_seen | req_ready), 32'd0);
        check({tag, ".result"}, resp_result, exp_res);
        check({tag, ".zero"}, 32'(resp_zero), 32'(exp_res == 32'd0));
        check({tag, ".illegal"}, 32'(resp_illegal), 32'(exp_ill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_result"}, resp_result, exp_res);
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ".ack_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".ack_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_function = '0;
        req_a        = '0;
        req_b        = '0;
        resp_ready   = 1'b0;
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.result", resp_result, 32'd0);
        check("reset.zero", 32'(resp_zero), 32'd1);
        check("reset.illegal", 32'(resp_illegal), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0, 0);
        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, shift_lat(4), 1'b0, 0);
        run_op("sll0", ALU_SLL, 32'h1, 32'd0, 32'h1, 1, 1'b0, 0);
        run_op("sll31", ALU_SLL, 32'h1, 32'd31, 32'h8000_0000, shift_lat(31), 1'b0, 0);
        run_op("srl3", ALU_SRL, 32'h8000_0000, 32'd3, 32'h1000_0000, shift_lat(3), 1'b0, 0);
        run_op("srl_hi_b", ALU_SRL, 32'hF000_000F, 32'hFFFF_FFE1, 32'h7800_0007, shift_lat(1),
               1'b0, 0);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1, 1'b0, 0);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 1'b0, 0);
        run_op("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0, 0);
        run_op("seq_t", ALU_SEQ, 32'h1234, 32'h1234, 32'd1, 1, 1'b0, 0);
        run_op("seq_f", ALU_SEQ, 32'h1234, 32'h1235, 32'd0, 1, 1'b0, 0);
        run_op("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1, 1'b0, 0);
        run_op("xor_hold", ALU_XOR, 32'hF0, 32'hFF, 32'h0F, 1, 1'b0, 3);

        // Abort a serial shift with reset in its second cycle.
        req_valid    = 1'b1;
        req_function = ALU_SRL;
        req_a        = 32'hFFFF_FFFF;
        req_b        = 32'd10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.resp_valid", 32'(resp_valid), 32'd0);
        check("abort.req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b0, 0);
        run_op("illegal", 5'b11111, 32'h1234_5678, 32'h1, 32'd0, 1, 1'b1, 0);
        run_op("after_ill", ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
